// File: rtl/sc_timebase_counter.sv
// rtl/sc_timebase_counter.sv - game timebase: prescaler, start/pause button, elapsed-time counter
// Optional build macro SC_TIMEBASE_WRAP_EN: elapsed time wraps to 0 instead of saturating in DONE.
module sc_timebase_counter #(
   parameter int PRESCALER_COUNT = 50000000,
   parameter int PRESCALER_WIDTH = 26,
   parameter int TIME_WIDTH      = 4,
   parameter int TIME_MAX        = 15
) (
   input  logic                  SC_TIMEBASE_CLOCK_50,
   input  logic                  SC_TIMEBASE_RESET_InLow,
   input  logic                  SC_TIMEBASE_START_InLow,
   input  logic                  SC_TIMEBASE_CLEAR_InHigh,
   output logic [TIME_WIDTH-1:0] SC_TIMEBASE_TIME_OutBUS,
   output logic                  SC_TIMEBASE_TICK_Out,
   output logic                  SC_TIMEBASE_RUNNING_Out,
   output logic                  SC_TIMEBASE_DONE_Out
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

   localparam logic [PRESCALER_WIDTH-1:0] PRESC_LAST = PRESCALER_WIDTH'(PRESCALER_COUNT - 1);
   localparam logic [TIME_WIDTH-1:0]      TIME_LAST  = TIME_WIDTH'(TIME_MAX);

   state_t                     state, state_nxt;
   logic [PRESCALER_WIDTH-1:0] presc, presc_nxt;
   logic [TIME_WIDTH-1:0]      time_r, time_nxt;
   logic                       tick_r, tick_nxt;
   logic                       sync1, sync2, edge_q;
   logic                       start_evt;

   // Button idles high; a press is the high-to-low transition after synchronization.
   assign start_evt = edge_q & ~sync2;

   always_comb begin
      state_nxt = state;
      presc_nxt = presc;
      time_nxt  = time_r;
      tick_nxt  = 1'b0;

      if (state == S_RUN) begin
         if (presc == PRESC_LAST) begin
            presc_nxt = '0;
            tick_nxt  = 1'b1;
         end else begin
            presc_nxt = presc + PRESCALER_WIDTH'(1);
         end
      end

      case (state)
         S_IDLE:  if (start_evt) state_nxt = S_RUN;
         S_RUN:   if (start_evt) state_nxt = S_PAUSE;
         S_PAUSE: if (start_evt) state_nxt = S_RUN;
         default: state_nxt = state;
      endcase

      // The tick registered last cycle is counted now, even if a press moved us to PAUSE.
      if (tick_r) begin
`ifdef SC_TIMEBASE_WRAP_EN
         time_nxt = (time_r == TIME_LAST) ? '0 : time_r + TIME_WIDTH'(1);
`else
         if (time_r != TIME_LAST) time_nxt = time_r + TIME_WIDTH'(1);
         if (time_r + TIME_WIDTH'(1) == TIME_LAST) state_nxt = S_DONE;
`endif
      end

      if (SC_TIMEBASE_CLEAR_InHigh) begin
         state_nxt = S_IDLE;
         presc_nxt = '0;
         time_nxt  = '0;
         tick_nxt  = 1'b0;
      end
   end

   always_ff @(posedge SC_TIMEBASE_CLOCK_50 or negedge SC_TIMEBASE_RESET_InLow) begin
      if (!SC_TIMEBASE_RESET_InLow) begin
         state  <= S_IDLE;
         presc  <= '0;
         time_r <= '0;
         tick_r <= 1'b0;
         sync1  <= 1'b1;
         sync2  <= 1'b1;
         edge_q <= 1'b1;
      end else begin
         sync1  <= SC_TIMEBASE_START_InLow;
         sync2  <= sync1;
         edge_q <= sync2;
         state  <= state_nxt;
         presc  <= presc_nxt;
         time_r <= time_nxt;
         tick_r <= tick_nxt;
      end
   end

   assign SC_TIMEBASE_TIME_OutBUS = time_r;
   assign SC_TIMEBASE_TICK_Out    = tick_r;
   assign SC_TIMEBASE_RUNNING_Out = (state == S_RUN);
`ifdef SC_TIMEBASE_WRAP_EN
   assign SC_TIMEBASE_DONE_Out    = 1'b0;
`else
   assign SC_TIMEBASE_DONE_Out    = (state == S_DONE);
`endif

endmodule

// File: tb/tb_sc_timebase_counter.sv
// tb/tb_sc_timebase_counter.sv - randomized self-checking bench for sc_timebase_counter
module tb_sc_timebase_counter;

   localparam int PC = 4;
   localparam int TM = 5;
   localparam int TW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start_n;
   logic          clear;
   logic [TW-1:0] time_o;
   logic          tick_o, run_o, done_o;

   int checks   = 0;
   int failures = 0;

   sc_timebase_counter #(
      .PRESCALER_COUNT(PC), .PRESCALER_WIDTH(3), .TIME_WIDTH(TW), .TIME_MAX(TM)
   ) dut (
      .SC_TIMEBASE_CLOCK_50    (clk),
      .SC_TIMEBASE_RESET_InLow (rst_n),
      .SC_TIMEBASE_START_InLow (start_n),
      .SC_TIMEBASE_CLEAR_InHigh(clear),
      .SC_TIMEBASE_TIME_OutBUS (time_o),
      .SC_TIMEBASE_TICK_Out    (tick_o),
      .SC_TIMEBASE_RUNNING_Out (run_o),
      .SC_TIMEBASE_DONE_Out    (done_o)
   );

   always #5 clk = ~clk;

   // Reference model: mode 0 idle, 1 run, 2 pause, 3 done.
   int m_mode, m_run_clocks, m_time;
   bit m_tick;
   bit hist[$];

`ifdef SC_TIMEBASE_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif

   task automatic model_reset();
      m_mode = 0; m_run_clocks = 0; m_time = 0; m_tick = 1'b0;
      hist = '{1'b1, 1'b1, 1'b1, 1'b1};
   endtask

   function automatic logic [TW+2:0] exp_vec();
      return {TW'(m_time), m_tick, (m_mode == 1), (m_mode == 3)};
   endfunction

   // Drive one clock of inputs and advance the model; returns #1 after the edge.
   task automatic step(input bit pin, input bit clr);
      bit evt, new_tick;
      int nm;
      start_n = pin;
      clear   = clr;
      @(posedge clk);
      hist.push_front(pin);
      evt = hist[3] && !hist[2];
      void'(hist.pop_back());
      if (clr) begin
         m_mode = 0; m_run_clocks = 0; m_time = 0; m_tick = 1'b0;
      end else begin
         nm = m_mode;
         new_tick = 1'b0;
         if (m_mode == 1) begin
            m_run_clocks++;
            new_tick = (m_run_clocks % PC) == 0;
         end
         if (evt) begin
            if (m_mode == 0 || m_mode == 2) nm = 1;
            else if (m_mode == 1) nm = 2;
         end
         if (m_tick) begin
            if (WRAP) m_time = (m_time == TM) ? 0 : m_time + 1;
            else begin
               m_time++;
               if (m_time == TM) nm = 3;
            end
         end
         m_mode = nm;
         m_tick = new_tick;
      end
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b1; start_n = 1'b1; clear = 1'b0;
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({time_o, tick_o, run_o, done_o} !== '0) begin
         failures++;
         $display("FAIL reset_hold got=%b want=0", {time_o, tick_o, run_o, done_o});
      end
      rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 1'b0);
         checks++;
         if ({time_o, tick_o, run_o, done_o} !== '0 || exp_vec() !== '0) begin
            failures++;
            $display("FAIL reset_idle cyc=%0d got=%b want=0", i, {time_o, tick_o, run_o, done_o});
         end
      end
   endtask

   task automatic test_start_run();
      for (int i = 0; i < 17; i++) begin
         step((i < 2) ? 1'b0 : 1'b1, 1'b0);
         checks++;
         if ({time_o, tick_o, run_o, done_o} !== exp_vec()) begin
            failures++;
            $display("FAIL start_run cyc=%0d got=%b want=%b", i, {time_o, tick_o, run_o, done_o}, exp_vec());
         end
         if (i == 2) begin
            checks++;
            if (run_o !== 1'b1) begin
               failures++;
               $display("FAIL start_latency got=%b want=1", run_o);
            end
         end
      end
   endtask

   task automatic test_pause_resume();
      for (int i = 0; i < 24; i++) begin
         step((i == 0 || i == 13) ? 1'b0 : 1'b1, 1'b0);
         checks++;
         if ({time_o, tick_o, run_o, done_o} !== exp_vec()) begin
            failures++;
            $display("FAIL pause_resume cyc=%0d got=%b want=%b", i, {time_o, tick_o, run_o, done_o}, exp_vec());
         end
      end
   endtask

   task automatic test_saturate();
      step(1'b1, 1'b1);
      for (int i = 0; i < 44; i++) begin
         step((i == 0 || i == 34 || i == 38) ? 1'b0 : 1'b1, 1'b0);
         checks++;
         if ({time_o, tick_o, run_o, done_o} !== exp_vec()) begin
            failures++;
            $display("FAIL saturate cyc=%0d got=%b want=%b", i, {time_o, tick_o, run_o, done_o}, exp_vec());
         end
      end
      checks++;
      if (done_o !== !WRAP || (!WRAP && time_o !== TW'(TM))) begin
         failures++;
         $display("FAIL saturate_end done=%b time=%0d want done=%b", done_o, time_o, !WRAP);
      end
   endtask

   task automatic test_clear_with_start();
      int n;
      step(1'b1, 1'b1);
      step(1'b0, 1'b0);
      n = 0;
      while (!(m_time == 3 && m_mode == 1) && n < 60) begin
         step(1'b1, 1'b0);
         n++;
      end
      checks++;
      if (n >= 60 || time_o !== 3'(3)) begin
         failures++;
         $display("FAIL clear_setup time=%0d want=3", time_o);
      end
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      checks++;
      if (time_o !== '0 || run_o !== 1'b0 || exp_vec() !== '0) begin
         failures++;
         $display("FAIL clear_drop_evt time=%0d run=%b want time=0 run=0", time_o, run_o);
      end
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b0);
         checks++;
         if ({time_o, tick_o, run_o, done_o} !== exp_vec() || run_o !== 1'b0) begin
            failures++;
            $display("FAIL clear_stay_idle cyc=%0d got=%b want=%b", i, {time_o, tick_o, run_o, done_o}, exp_vec());
         end
      end
   endtask

   task automatic test_random();
      bit pin = 1'b1;
      int hold = 0;
      for (int i = 0; i < 500; i++) begin
         if (hold == 0) begin
            pin  = $urandom_range(0, 2) != 0;
            hold = $urandom_range(1, 6);
         end
         hold--;
         step(pin, $urandom_range(0, 39) == 0);
         checks++;
         if ({time_o, tick_o, run_o, done_o} !== exp_vec()) begin
            failures++;
            $display("FAIL random cyc=%0d got=%b want=%b", i, {time_o, tick_o, run_o, done_o}, exp_vec());
         end
      end
   endtask

   task automatic test_async_reset();
      int n;
      step(1'b1, 1'b1);
      step(1'b0, 1'b0);
      n = 0;
      while (!(m_time == 2 && m_mode == 1) && n < 60) begin
         step(1'b1, 1'b0);
         n++;
      end
      checks++;
      if (n >= 60 || time_o !== TW'(2)) begin
         failures++;
         $display("FAIL async_setup time=%0d want=2", time_o);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({time_o, tick_o, run_o, done_o} !== '0) begin
         failures++;
         $display("FAIL async_reset got=%b want=0", {time_o, tick_o, run_o, done_o});
      end
      rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < 8; i++) begin
         step((i < 2) ? 1'b0 : 1'b1, 1'b0);
         checks++;
         if ({time_o, tick_o, run_o, done_o} !== exp_vec()) begin
            failures++;
            $display("FAIL after_reset cyc=%0d got=%b want=%b", i, {time_o, tick_o, run_o, done_o}, exp_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_start_run();
      test_pause_resume();
      test_saturate();
      test_clear_with_start();
      test_random();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
